// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: one word request at a time,
// fixed access latency, single-cycle response pulse, word-addressed RAM behind it.
module data_mem_responder #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_error_q, resp_error_d;
  logic          rdata_sel_q, rdata_sel_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          commit;
  logic          addr_err;
  logic [IW-1:0] idx;

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   ram_rd_q;

  assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH));
  assign idx      = addr_q[IW+1:2];

  // The access is committed when the counter has run out, i.e. on edge E0+LATENCY,
  // which puts the response pulse in the following cycle for every LATENCY >= 1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    rdata_sel_d  = rdata_sel_q;
    commit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit       = 1'b1;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = addr_err;
          rdata_sel_d  = !addr_err && !write_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      rdata_sel_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      rdata_sel_q  <= rdata_sel_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  // RAM and its read register are never reset; an async reset drops state_q to
  // IDLE, so an in-flight store cannot commit afterwards.
  always_ff @(posedge clk) begin
    if (commit && !addr_err) begin
      if (write_q) mem[idx] <= wdata_q;
      else         ram_rd_q <= mem[idx];
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = rdata_sel_q ? ram_rd_q : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=4 instance for the main flow,
// LATENCY=1 instance for the short-latency and back-to-back cases.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_resp_valid, a_resp_error, a_busy;
  logic [31:0] a_resp_rdata;

  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_resp_valid, b_resp_error, b_busy;
  logic [31:0] b_resp_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_DEPTH(16384), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_error(a_resp_error), .busy(a_busy)
  );

  data_mem_responder #(.MEM_DEPTH(16384), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_error(b_resp_error), .busy(b_busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full LATENCY=4 transaction starting from IDLE, checking every cycle.
  task automatic a_txn(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    chk1({tag, ".ready"}, a_ready, 1'b1);
    a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = wd;
    tick();
    a_valid = 1'b0; a_write = 1'b0; a_addr = 32'hFFFF_FFFF; a_wdata = 32'h0;
    chk1({tag, ".busy0"}, a_busy, 1'b1);
    chk1({tag, ".rv0"}, a_resp_valid, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1($sformatf("%s.rv%0d", tag, k), a_resp_valid, (k == 4));
      chk1($sformatf("%s.busy%0d", tag, k), a_busy, 1'b1);
    end
    chk32({tag, ".rdata"}, a_resp_rdata, exp_rd);
    chk1({tag, ".err"}, a_resp_error, exp_err);
    tick();
    chk1({tag, ".rv_end"}, a_resp_valid, 1'b0);
    chk1({tag, ".busy_end"}, a_busy, 1'b0);
    chk32({tag, ".rdata_hold"}, a_resp_rdata, exp_rd);
    $display("txn %-8s %s addr=%h wdata=%h rdata=%h err=%b", tag, w ? "ST" : "LD",
             addr, wd, a_resp_rdata, a_resp_error);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk1("rst.rv", a_resp_valid, 1'b0);
    chk32("rst.rdata", a_resp_rdata, 32'h0);
    chk1("rst.err", a_resp_error, 1'b0);
    chk1("rst.busy", a_busy, 1'b0);
    chk1("rst.b_rv", b_resp_valid, 1'b0);
    #20 reset = 1'b1;
    tick();
    chk1("rst.ready", a_ready, 1'b1);
    $display("txn reset    released");

    // 1-3: store, load back, misaligned load, load again
    a_txn("t1", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    a_txn("t2", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    a_txn("t3a", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    a_txn("t3b", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // 4: request held through BUSY/RESP is accepted as soon as IDLE returns
    a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
    tick();
    a_write = 1'b1; a_addr = 32'h30; a_wdata = 32'h0BADF00D;
    for (int k = 1; k <= 4; k++) begin
      chk1($sformatf("t4.ready%0d", k), a_ready, 1'b0);
      tick();
    end
    chk1("t4.rv", a_resp_valid, 1'b1);
    chk32("t4.rdata", a_resp_rdata, 32'hDEADBEEF);
    chk1("t4.ready_resp", a_ready, 1'b0);
    tick();
    chk1("t4.ready_idle", a_ready, 1'b1);
    chk1("t4.busy_idle", a_busy, 1'b0);
    tick();
    a_valid = 1'b0;
    chk1("t4.accepted", a_busy, 1'b1);
    for (int k = 1; k <= 4; k++) tick();
    chk1("t4.rv2", a_resp_valid, 1'b1);
    chk1("t4.err2", a_resp_error, 1'b0);
    chk32("t4.rdata2", a_resp_rdata, 32'h0);
    tick();
    $display("txn t4       held request accepted after RESP");
    a_txn("t4c", 1'b0, 32'h30, 32'h0, 32'h0BADF00D, 1'b0);

    // 5: reset mid-store drops the store and its response
    a_txn("t5a", 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk1("t5.busy_rst", a_busy, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1($sformatf("t5.rv_rst%0d", k), a_resp_valid, 1'b0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("t5.rv_post%0d", k), a_resp_valid, 1'b0);
    end
    $display("txn t5       store dropped by reset");
    a_txn("t5c", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    // 6: LATENCY=1 out-of-range load, then back-to-back store and load
    chk1("t6.ready", b_ready, 1'b1);
    b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h0001_0000;
    tick();
    b_write = 1'b1; b_addr = 32'h4; b_wdata = 32'hCAFEF00D;
    chk1("t6.busy0", b_busy, 1'b1);
    chk1("t6.rv0", b_resp_valid, 1'b0);
    tick();
    chk1("t6.rv1", b_resp_valid, 1'b1);
    chk1("t6.err1", b_resp_error, 1'b1);
    chk32("t6.rdata1", b_resp_rdata, 32'h0);
    tick();
    chk1("t6.rv2", b_resp_valid, 1'b0);
    chk1("t6.ready2", b_ready, 1'b1);
    tick();
    b_write = 1'b0; b_addr = 32'h4; b_wdata = 32'h0;
    chk1("t6.accept3", b_busy, 1'b1);
    chk1("t6.ready3", b_ready, 1'b0);
    tick();
    chk1("t6.rv4", b_resp_valid, 1'b1);
    chk1("t6.err4", b_resp_error, 1'b0);
    tick();
    tick();
    b_valid = 1'b0;
    chk1("t6.accept6", b_busy, 1'b1);
    tick();
    chk1("t6.rv7", b_resp_valid, 1'b1);
    chk32("t6.rdata7", b_resp_rdata, 32'hCAFEF00D);
    chk1("t6.err7", b_resp_error, 1'b0);
    tick();
    chk1("t6.rv8", b_resp_valid, 1'b0);
    $display("txn t6       LATENCY=1 error load, store, load rdata=%h", b_resp_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
